// File: rtl/bram_pkg.sv
// Shared defaults and pointer helpers for the 256x16 BRAM block and its FIFO controller.
package bram_pkg;

    localparam int BRAM_AW       = 8;
    localparam int BRAM_DW       = 16;
    localparam int BRAM_PF_DEPTH = 2;

    // The MSB is the wrap bit, so equal low bits mean either empty or full.
    typedef logic [BRAM_AW:0] ptr_t;

    function automatic logic ptr_full(input ptr_t wr, input ptr_t rd);
        return (wr[BRAM_AW] != rd[BRAM_AW]) && (wr[BRAM_AW-1:0] == rd[BRAM_AW-1:0]);
    endfunction

    function automatic logic ptr_empty(input ptr_t wr, input ptr_t rd);
        return wr == rd;
    endfunction

endpackage

// File: rtl/bram_prefetch_buf.sv
// Small register FIFO that holds read data returned by the BRAM and presents the FIFO head.
module bram_prefetch_buf
    import bram_pkg::*;
#(
    parameter int DEPTH = BRAM_PF_DEPTH,
    parameter int DW    = BRAM_DW,
    parameter int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          push,
    input  logic [DW-1:0] push_data,
    input  logic          pop,
    output logic [CW-1:0] count,
    output logic          valid,
    output logic [DW-1:0] head
);

    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0][DW-1:0] slots;
    logic [IW-1:0]            head_idx;
    logic [IW-1:0]            tail_idx;

    function automatic logic [IW-1:0] nxt(input logic [IW-1:0] i);
        return (i == IW'(DEPTH - 1)) ? '0 : i + 1'b1;
    endfunction

    assign valid = (count != '0);
    assign head  = slots[head_idx];

    // Ring buffer: write at tail, read at head; a push and pop together keep count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slots    <= '0;
            head_idx <= '0;
            tail_idx <= '0;
            count    <= '0;
        end else if (clear) begin
            head_idx <= '0;
            tail_idx <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                slots[tail_idx] <= push_data;
                tail_idx        <= nxt(tail_idx);
            end
            if (pop) head_idx <= nxt(head_idx);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // The credit check upstream makes overflow impossible.
    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !clear && count == CW'(DEPTH)));

endmodule

// File: rtl/bram_fifo_ctrl.sv
// Ready/valid FIFO front-end for the explicit BRAM block, with read latency hidden by prefetch.
module bram_fifo_ctrl
    import bram_pkg::*;
#(
    parameter int AW       = BRAM_AW,
    parameter int DW       = BRAM_DW,
    parameter int PF_DEPTH = BRAM_PF_DEPTH
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    input  logic          wr_valid,
    output logic          wr_ready,
    input  logic [DW-1:0] wr_data,
    output logic          rd_valid,
    input  logic          rd_ready,
    output logic [DW-1:0] rd_data,
    output logic [AW+1:0] level,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_wr_addr,
    output logic [DW-1:0] mem_wr_data,
    output logic          mem_rd_en,
    output logic [AW-1:0] mem_rd_addr,
    input  logic [DW-1:0] mem_rd_data,
    input  logic          mem_rd_valid
);

    localparam int CW  = $clog2(PF_DEPTH + 1);
    // Discards can pile up across back-to-back clears while reads are still in flight.
    localparam int DCW = CW + 2;

    logic [AW:0]    wr_ptr, rd_ptr, commit_ptr, mem_cnt;
    logic [CW-1:0]  outstanding, pf_count;
    logic [DCW-1:0] discard;
    logic [AW+1:0]  level_q;
    logic [CW:0]    used;
    logic           ready_q, full, push, pop, issue, ret_keep, ret_drop;

    assign mem_cnt  = wr_ptr - rd_ptr;
    assign full     = (mem_cnt == {1'b1, {AW{1'b0}}});
    assign wr_ready = ready_q & ~full & ~clear;
    assign push     = wr_valid & wr_ready;
    assign pop      = rd_valid & rd_ready & ~clear;
    // A slot freed by this cycle's pop can already be re-used by this cycle's issue.
    assign used     = (CW+1)'(outstanding) + (CW+1)'(pf_count) - (CW+1)'(pop);
    assign issue    = ~clear & (commit_ptr != rd_ptr) & (used < (CW+1)'(PF_DEPTH));
    assign ret_drop = mem_rd_valid & (discard != '0);
    assign ret_keep = mem_rd_valid & (discard == '0);

    assign mem_wr_en   = push;
    assign mem_wr_addr = wr_ptr[AW-1:0];
    assign mem_wr_data = push ? wr_data : '0;
    assign mem_rd_en   = issue;
    assign mem_rd_addr = rd_ptr[AW-1:0];
    assign level       = level_q;

    // Holds wr_ready low through reset and raises it on the first clock afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) ready_q <= 1'b0;
        else        ready_q <= 1'b1;
    end

    // Pointers, read credits and level. commit_ptr takes the post-write pointer: the write
    // lands on this edge, so anything below it can be read from the next cycle on.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            commit_ptr  <= '0;
            outstanding <= '0;
            discard     <= '0;
            level_q     <= '0;
        end else if (clear) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            commit_ptr  <= '0;
            outstanding <= '0;
            discard     <= discard + DCW'(outstanding) - DCW'(mem_rd_valid);
            level_q     <= '0;
        end else begin
            wr_ptr      <= wr_ptr + (AW+1)'(push);
            commit_ptr  <= wr_ptr + (AW+1)'(push);
            rd_ptr      <= rd_ptr + (AW+1)'(issue);
            outstanding <= outstanding + CW'(issue) - CW'(ret_keep);
            discard     <= discard - DCW'(ret_drop);
            level_q     <= level_q + (AW+2)'(push) - (AW+2)'(pop);
        end
    end

    bram_prefetch_buf #(.DEPTH(PF_DEPTH), .DW(DW), .CW(CW)) u_pf (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (clear),
        .push      (ret_keep),
        .push_data (mem_rd_data),
        .pop       (pop),
        .count     (pf_count),
        .valid     (rd_valid),
        .head      (rd_data)
    );

    // Every return must belong to a read we issued.
    a_ret_expected: assert property (@(posedge clk) disable iff (!rst_n)
        mem_rd_valid |-> (outstanding != '0 || discard != '0));

endmodule

// File: tb/tb_bram_fifo_ctrl.sv
// Scoreboard bench for bram_fifo_ctrl with a behavioural BRAM of selectable read latency.
module tb_bram_fifo_ctrl;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0, rst_n = 1'b0, clear = 1'b0;
    logic          wr_valid = 1'b0, rd_ready = 1'b0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ready, rd_valid;
    logic [DW-1:0] rd_data;
    logic [AW+1:0] level;
    logic          mem_wr_en, mem_rd_en, mem_rd_valid;
    logic [AW-1:0] mem_wr_addr, mem_rd_addr;
    logic [DW-1:0] mem_wr_data, mem_rd_data;

    int checks = 0;
    int fails  = 0;

    // Reference model: the FIFO is simply the words accepted and not yet popped.
    logic [DW-1:0] exp_q[$];
    logic [AW-1:0] wa_exp = '0;

    bram_fifo_ctrl dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .level(level),
        .mem_wr_en(mem_wr_en), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_en(mem_rd_en), .mem_rd_addr(mem_rd_addr),
        .mem_rd_data(mem_rd_data), .mem_rd_valid(mem_rd_valid)
    );

    always #5 clk = ~clk;

    // Memory: read latency = lat_sel+1 cycles, changed only while no read is in flight.
    logic [DW-1:0]       marr [256];
    logic [2:0]          mv;
    logic [2:0][DW-1:0]  md;
    logic [1:0]          lat_sel = 2'd0;

    always @(posedge clk) if (mem_wr_en) marr[mem_wr_addr] <= mem_wr_data;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) mv <= '0;
        else begin
            mv <= {mv[1:0], mem_rd_en};
            md <= {md[1:0], marr[mem_rd_addr]};
        end
    end
    assign mem_rd_valid = mv[lat_sel];
    assign mem_rd_data  = md[lat_sel];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drain everything with rd_ready held high; bounded.
    task automatic drain();
        int n;
        n = 0;
        rd_ready = 1'b1;
        wr_valid = 1'b0;
        while ((level != '0 || rd_valid) && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("drain_in_time", 32'(n < 600), 32'd1);
        step();
        rd_ready = 1'b0;
    endtask

    // Monitor: level, head data and write address against the model, then apply handshakes.
    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            wa_exp = '0;
        end else begin
            chk("level", 32'(level), 32'(exp_q.size()));
            if (rd_valid) begin
                if (exp_q.size() == 0) chk("rd_valid_when_empty", 32'(rd_valid), 32'd0);
                else                   chk("rd_data", 32'(rd_data), 32'(exp_q[0]));
            end
            if (mem_wr_en) chk("mem_wr_addr", 32'(mem_wr_addr), 32'(wa_exp));
            if (clear) begin
                exp_q.delete();
                wa_exp = '0;
            end else begin
                if (rd_valid && rd_ready && exp_q.size() > 0) void'(exp_q.pop_front());
                if (wr_valid && wr_ready) begin
                    exp_q.push_back(wr_data);
                    wa_exp = wa_exp + 1'b1;
                end
            end
        end
    end

    initial begin
        int n_acc, fires, pushed, n;

        // 1: reset, then async reset in the middle of a push burst
        step(); step();
        rst_n = 1'b1;
        step();
        chk("wr_ready_after_reset", 32'(wr_ready), 32'd1);
        chk("rd_valid_after_reset", 32'(rd_valid), 32'd0);
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = DW'(16'h100 + i);
            step();
        end
        rst_n = 1'b0;
        #2;
        chk("rst_wr_ready", 32'(wr_ready), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid), 32'd0);
        chk("rst_level", 32'(level), 32'd0);
        chk("rst_mem_wr_en", 32'(mem_wr_en), 32'd0);
        chk("rst_mem_rd_en", 32'(mem_rd_en), 32'd0);
        chk("rst_mem_wr_addr", 32'(mem_wr_addr), 32'd0);
        chk("rst_mem_wr_data", 32'(mem_wr_data), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        step(); step();
        wr_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("wr_ready_first_cycle", 32'(wr_ready), 32'd1);
        chk("rd_valid_post_reset", 32'(rd_valid), 32'd0);
        chk("level_post_reset", 32'(level), 32'd0);

        // 2: push 1..5 with rd_ready low; fall-through is latency+2 (latency 1 here)
        lat_sel = 2'd0;
        wr_valid = 1'b1;
        wr_data = 16'h0001;
        step();
        wr_data = 16'h0002;
        @(negedge clk) chk("fallthrough_c1", 32'(rd_valid), 32'd0);
        step();
        wr_data = 16'h0003;
        @(negedge clk) chk("fallthrough_c2", 32'(rd_valid), 32'd0);
        step();
        wr_data = 16'h0004;
        @(negedge clk) chk("fallthrough_c3", 32'(rd_valid), 32'd1);
        step();
        wr_data = 16'h0005;
        step();
        wr_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_level5", 32'(level), 32'd5);
            chk("hold_rd_data", 32'(rd_data), 32'h0001);
            step();
        end
        drain();

        // 3: fill until refused; capacity is 256 in BRAM plus 2 prefetched
        wr_valid = 1'b1;
        wr_data = DW'($urandom);
        n_acc = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (!wr_ready) break;
            n_acc++;
            step();
            wr_data = DW'($urandom);
        end
        chk("accepted_to_full", 32'(n_acc), 32'd258);
        chk("level_full", 32'(level), 32'd258);
        for (int i = 0; i < 3; i++) begin
            step();
            @(negedge clk) chk("wr_ready_full", 32'(wr_ready), 32'd0);
        end
        step();
        wr_valid = 1'b0;
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        @(negedge clk);
        chk("wr_ready_after_pop", 32'(wr_ready), 32'd1);
        chk("level_after_pop", 32'(level), 32'd257);
        step();
        drain();

        // 4: clear, then 300 random pushes/pops across the address wrap (latency 2)
        lat_sel = 2'd1;
        clear = 1'b1;
        step();
        clear = 1'b0;
        pushed = 0;
        n = 0;
        while ((pushed < 300 || level != '0) && n < 4000) begin
            wr_valid = (pushed < 300) && ($urandom_range(3) != 0);
            wr_data  = DW'($urandom);
            rd_ready = $urandom_range(1) == 1;
            @(negedge clk);
            if (wr_valid && wr_ready) pushed++;
            step();
            n++;
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        chk("wrap_pushed", 32'(pushed), 32'd300);
        chk("wrap_wr_addr_next", 32'(mem_wr_addr), 32'd44);
        drain();

        // 5: level 3, push and pop every cycle for 100 cycles (latency 1)
        lat_sel = 2'd0;
        wr_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_data = DW'($urandom);
            step();
        end
        wr_valid = 1'b0;
        repeat (6) step();
        chk("level3_start", 32'(level), 32'd3);
        fires = 0;
        wr_valid = 1'b1;
        rd_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            wr_data = DW'($urandom);
            @(negedge clk);
            if (wr_valid && wr_ready && rd_valid && rd_ready) fires++;
            step();
        end
        wr_valid = 1'b0;
        rd_ready = 1'b0;
        chk("streaming_fires", 32'(fires), 32'd100);
        chk("level3_end", 32'(level), 32'd3);
        drain();

        // 6: clear with two reads in flight (latency 3); late returns must vanish
        lat_sel = 2'd2;
        wr_valid = 1'b1;
        wr_data = 16'hAAAA;
        step();
        wr_data = 16'h5555;
        step();
        wr_valid = 1'b0;
        step();
        clear = 1'b1;
        step();
        clear = 1'b0;
        @(negedge clk);
        chk("clear_level", 32'(level), 32'd0);
        chk("clear_rd_valid", 32'(rd_valid), 32'd0);
        for (int i = 0; i < 6; i++) begin
            step();
            @(negedge clk) chk("late_return_dropped", 32'(rd_valid), 32'd0);
        end
        step();
        wr_valid = 1'b1;
        wr_data = 16'hBEEF;
        step();
        wr_valid = 1'b0;
        n = 0;
        while (!rd_valid && n < 20) begin
            step();
            n++;
        end
        chk("beef_valid", 32'(rd_valid), 32'd1);
        chk("beef_data", 32'(rd_data), 32'hBEEF);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

    initial begin
        #2000000;
        fails++;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $fatal(1, "watchdog");
    end

endmodule
